// File: rtl/button_encoder_4to2_pkg.sv
// Shared definitions for the button encoder and its companion 2-to-4 digit decoder.
package button_encoder_4to2_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [1:0] CODE_BTN0 = 2'b00;
  localparam logic [1:0] CODE_BTN1 = 2'b01;
  localparam logic [1:0] CODE_BTN2 = 2'b10;
  localparam logic [1:0] CODE_BTN3 = 2'b11;

endpackage

// File: rtl/button_encoder_4to2_sync_2ff.sv
// Two-flop synchroniser bringing asynchronous lines into the clk domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_encoder_4to2.sv
// Debounced priority encoder for four buttons; one valid/ready event per press.
module button_encoder_4to2
  import button_encoder_4to2_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       ready,
  output logic       valid,
  output logic [1:0] code,
  output logic       multi
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [1:0] enc(input logic [3:0] p);
    logic [1:0] c;
    c = CODE_BTN0;
    if (p[1]) c = CODE_BTN1;
    if (p[2]) c = CODE_BTN2;
    if (p[3]) c = CODE_BTN3;
    return c;
  endfunction

  function automatic logic is_multi(input logic [3:0] p);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, p[i]};
    return n > 3'd1;
  endfunction

  logic [3:0]       s;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       pat, pat_nx;
  logic             valid_nx, multi_nx;
  logic [1:0]       code_nx;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn),
    .q     (s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pat   <= '0;
      valid <= 1'b0;
      code  <= CODE_BTN0;
      multi <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pat   <= pat_nx;
      valid <= valid_nx;
      code  <= code_nx;
      multi <= multi_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pat_nx   = pat;
    valid_nx = valid;
    code_nx  = code;
    multi_nx = multi;
    unique case (state)
      IDLE: begin
        if (s != 4'b0000) begin
          pat_nx   = s;
          cnt_nx   = CNT_ONE;
          state_nx = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (s == 4'b0000) begin
          state_nx = IDLE;
        end else if (s != pat) begin
          // A different chord restarts the stability window.
          pat_nx = s;
          cnt_nx = CNT_ONE;
        end else if (cnt == CNT_MAX) begin
          valid_nx = 1'b1;
          code_nx  = enc(pat);
          multi_nx = is_multi(pat);
          state_nx = HOLD;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      HOLD: begin
        if (ready) begin
          valid_nx = 1'b0;
          cnt_nx   = '0;
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        // Any activity restarts the release window so a held press cannot re-fire.
        if (s != 4'b0000) begin
          cnt_nx = '0;
        end else if (cnt == CNT_MAX) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
